// File: rtl/cordic_lut_sequencer_pkg.sv
// Shared definitions for the hyperbolic-CORDIC run sequencer.
package cordic_lut_sequencer_pkg;

  localparam int D_DEF      = 5;
  localparam int N_ITER_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    ITER = 2'b10,
    DONE = 2'b11
  } seq_state_t;

endpackage

// File: rtl/cordic_iter_counter.sv
// Saturating iteration counter: clear wins over enable, never wraps past N_ITER-1.
module cordic_iter_counter
  import cordic_lut_sequencer_pkg::*;
#(
  parameter int D      = D_DEF,
  parameter int N_ITER = N_ITER_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         en,
  output logic [D-1:0] cnt,
  output logic         is_last
);

  localparam logic [D-1:0] LAST_IDX = D'(N_ITER - 1);

  assign is_last = (cnt == LAST_IDX);

  // Count accepted iterations; hold at the last index.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                cnt <= '0;
    else if (clr)           cnt <= '0;
    else if (en && !is_last) cnt <= cnt + D'(1);
  end

endmodule

// File: rtl/cordic_lut_sequencer.sv
// Sequences one CORDIC run: ROM enable/address, iteration enables aligned with
// the 1-cycle ROM latency, stall retention and a held completion flag.
module cordic_lut_sequencer
  import cordic_lut_sequencer_pkg::*;
#(
  parameter int D      = D_DEF,
  parameter int N_ITER = N_ITER_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         BEG_SEQ,
  input  logic         STALL,
  input  logic         ACK_SEQ,
  output logic         EN_ROM1,
  output logic [D-1:0] ADRS,
  output logic         LOAD_INIT,
  output logic         EN_ITER,
  output logic [D-1:0] ITER_IDX,
  output logic         LAST_ITER,
  output logic         RDY
);

  seq_state_t state, state_nxt;
  logic       cnt_clr;
  logic       is_last;
  logic       rdy_q;

  // Counter is cleared entering ITER and leaving DONE, so it reads 0 in IDLE
  // and still shows the final index while RDY is up.
  cordic_iter_counter #(.D(D), .N_ITER(N_ITER)) u_cnt (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (cnt_clr),
    .en      (EN_ITER),
    .cnt     (ITER_IDX),
    .is_last (is_last)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Completion flag: up for exactly the cycles spent in DONE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rdy_q <= 1'b0;
    else     rdy_q <= (state_nxt == DONE);
  end

  assign RDY = rdy_q;

  // Next state and decoded outputs. In ITER the address runs one ahead so the
  // registered ROM word lines up with ITER_IDX; a stall re-reads the current word.
  always_comb begin
    state_nxt = state;
    EN_ROM1   = 1'b0;
    ADRS      = '0;
    LOAD_INIT = 1'b0;
    EN_ITER   = 1'b0;
    LAST_ITER = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      IDLE: if (BEG_SEQ) state_nxt = LOAD;
      LOAD: begin
        LOAD_INIT = 1'b1;
        EN_ROM1   = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = ITER;
      end
      ITER: begin
        EN_ROM1   = 1'b1;
        EN_ITER   = ~STALL;
        ADRS      = (STALL || is_last) ? ITER_IDX : ITER_IDX + D'(1);
        LAST_ITER = ~STALL & is_last;
        if (!STALL && is_last) state_nxt = DONE;
      end
      DONE: if (ACK_SEQ) begin
        state_nxt = IDLE;
        cnt_clr   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
